// File: rtl/joy2quad_multi.sv
// Multi-channel joystick to quadrature steering encoder.
// Each channel turns left/right requests into Gray-coded A/B phases, with optional step-rate acceleration.
//
// state | meaning
// IDLE  | no direction, or both directions, requested; timer parked at BASE_DIV-1
// RIGHT | stepping forward: {A,B} 00->01->11->10, pos increments
// LEFT  | stepping backward: {A,B} 00->10->11->01, pos decrements
module joy2quad_multi #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int BASE_DIV    = 22500,
    parameter int MIN_DIV     = 5625,
    parameter int ACCEL_STEP  = 1125,
    parameter int ACCEL_TICKS = 8
) (
    input  logic                    CLK,
    input  logic                    Reset_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [CHANNELS-1:0]     left,
    input  logic [CHANNELS-1:0]     right,
    output logic [2*CHANNELS-1:0]   steer,
    output logic [8*CHANNELS-1:0]   pos
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } dir_t;

    localparam int SC_W = $clog2(ACCEL_TICKS + 1);
    localparam logic [DIV_W-1:0] BASE_P   = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] BASE_CNT = DIV_W'(BASE_DIV - 1);
    localparam logic [DIV_W-1:0] MIN_P    = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] STEP_P   = DIV_W'(ACCEL_STEP);
    // One bit wider so MIN_DIV + ACCEL_STEP cannot wrap.
    localparam logic [DIV_W:0]   SAT_THR  = (DIV_W+1)'(MIN_DIV) + (DIV_W+1)'(ACCEL_STEP);
    localparam logic [SC_W-1:0]  TICKS    = SC_W'(ACCEL_TICKS);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        dir_t             dir_q;
        dir_t             dir_d;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] period_q;
        logic [DIV_W-1:0] new_period;
        logic [SC_W-1:0]  sc_q;
        logic [SC_W-1:0]  sc_inc;
        logic             accel_evt;
        logic [1:0]       steer_q;
        logic [7:0]       pos_q;

        always_comb begin
            dir_d = IDLE;
            if (right[g] && !left[g]) begin
                dir_d = RIGHT;
            end else if (left[g] && !right[g]) begin
                dir_d = LEFT;
            end
            sc_inc     = sc_q + 1'b1;
            accel_evt  = mode && (sc_inc == TICKS);
            new_period = BASE_P;
            if (mode) begin
                new_period = period_q;
                if (accel_evt) begin
                    new_period = ({1'b0, period_q} >= SAT_THR) ? (period_q - STEP_P) : MIN_P;
                end
            end
        end

        always_ff @(posedge CLK or negedge Reset_n) begin
            if (!Reset_n) begin
                dir_q    <= IDLE;
                cnt_q    <= BASE_CNT;
                period_q <= BASE_P;
                sc_q     <= '0;
                steer_q  <= 2'b00;
                pos_q    <= 8'd0;
            end else if (enable) begin
                dir_q <= dir_d;
                if (dir_d == IDLE || dir_d != dir_q) begin
                    cnt_q    <= BASE_CNT;
                    period_q <= BASE_P;
                    sc_q     <= '0;
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    cnt_q    <= new_period - 1'b1;
                    period_q <= new_period;
                    if (mode) begin
                        sc_q <= accel_evt ? '0 : sc_inc;
                    end
                    // Gray stepping: forward is {B,~A}, reverse is {~B,A}.
                    if (dir_q == RIGHT) begin
                        steer_q <= {steer_q[0], ~steer_q[1]};
                        pos_q   <= pos_q + 8'd1;
                    end else begin
                        steer_q <= {~steer_q[0], steer_q[1]};
                        pos_q   <= pos_q - 8'd1;
                    end
                end
            end
        end

        assign steer[2*g +: 2] = steer_q;
        assign pos[8*g +: 8]   = pos_q;
    end

endmodule
